// File: rtl/seq_match_pkg.sv
// Shared types and constants for the consecutive-match detector.
package seq_match_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    MATCHED  = 2'd2
  } state_t;

  localparam logic MODE_MEALY = 1'b0;
  localparam logic MODE_MOORE = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/seq_match_detector.sv
// Detects runs of MATCH_COUNT consecutive valid words matching pattern under mask,
// with selectable Mealy/Moore hit decoding and a saturating hit counter.
module seq_match_detector
  import seq_match_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MATCH_COUNT = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned RUN_W       = $clog2(MATCH_COUNT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] mask,
  output logic             hit,
  output logic [RUN_W-1:0] run_len,
  output logic [CNT_W-1:0] hit_count
);

  state_t           r_state;
  logic [RUN_W-1:0] r_run_len;
  logic [RUN_W-1:0] w_run_inc;
  logic             w_match;
  logic             w_beat;
  logic             w_full_next;
  logic             w_hit_event;

  assign w_match     = ((in_data ^ pattern) & mask) == '0;
  assign w_beat      = in_valid & ~reset & ~clr;
  assign w_run_inc   = (r_run_len == RUN_W'(MATCH_COUNT)) ? r_run_len : r_run_len + RUN_W'(1);
  // A match completes or extends a full run exactly when the incremented count reaches the limit.
  assign w_full_next = (w_run_inc == RUN_W'(MATCH_COUNT));
  assign w_hit_event = w_beat & w_match & w_full_next;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_state   <= IDLE;
      r_run_len <= '0;
    end else if (in_valid) begin
      if (w_match) begin
        r_run_len <= w_run_inc;
        r_state   <= w_full_next ? MATCHED : COUNTING;
      end else begin
        r_run_len <= '0;
        r_state   <= IDLE;
      end
    end
  end

  assign hit     = (mode == MODE_MOORE) ? (r_state == MATCHED) : w_hit_event;
  assign run_len = r_run_len;

  sat_counter #(
    .W(CNT_W)
  ) u_hit_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (clr),
    .i_inc  (w_hit_event),
    .o_count(hit_count)
  );

endmodule

// File: tb/tb_seq_match_detector.sv
// Bench for seq_match_detector: three configurations share one stimulus stream and
// are compared every cycle against a run-length model, plus literal expectations.
module tb_seq_match_detector;

  logic       clk = 1'b0;
  logic       reset, clr, mode, in_valid;
  logic [3:0] in_data, pattern, mask;

  logic        hit0, hit1, hit2;
  logic [1:0]  run0, run1;
  logic [0:0]  run2;
  logic [15:0] cnt0, cnt2;
  logic [1:0]  cnt1;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  int m_run [3] = '{0, 0, 0};
  int m_cnt [3] = '{0, 0, 0};
  int mc    [3] = '{2, 2, 1};
  int cmax  [3] = '{65535, 3, 65535};

  always #5 clk = ~clk;

  seq_match_detector u0 (
    .clk(clk), .reset(reset), .clr(clr), .mode(mode), .in_valid(in_valid),
    .in_data(in_data), .pattern(pattern), .mask(mask),
    .hit(hit0), .run_len(run0), .hit_count(cnt0)
  );

  seq_match_detector #(.CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .clr(clr), .mode(mode), .in_valid(in_valid),
    .in_data(in_data), .pattern(pattern), .mask(mask),
    .hit(hit1), .run_len(run1), .hit_count(cnt1)
  );

  seq_match_detector #(.MATCH_COUNT(1)) u2 (
    .clk(clk), .reset(reset), .clr(clr), .mode(mode), .in_valid(in_valid),
    .in_data(in_data), .pattern(pattern), .mask(mask),
    .hit(hit2), .run_len(run2), .hit_count(cnt2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit model_match();
    return ((in_data ^ pattern) & mask) == 4'h0;
  endfunction

  // Model: run length = consecutive matching valid words, capped at the match count.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int nr, nc;
      nr = m_run[k];
      nc = m_cnt[k];
      if (reset || clr) begin
        nr = 0;
        nc = 0;
      end else if (in_valid) begin
        if (model_match()) begin
          if (m_run[k] + 1 >= mc[k] && nc < cmax[k]) nc = nc + 1;
          nr = (m_run[k] + 1 > mc[k]) ? mc[k] : m_run[k] + 1;
        end else begin
          nr = 0;
        end
      end
      m_run[k] <= nr;
      m_cnt[k] <= nc;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < 3; k++) begin
        int exp_hit, a_hit, a_run, a_cnt;
        if (mode)
          exp_hit = (m_run[k] == mc[k]) ? 1 : 0;
        else
          exp_hit = (!reset && !clr && in_valid && model_match() && m_run[k] + 1 >= mc[k]) ? 1 : 0;
        case (k)
          0:       begin a_hit = int'(hit0); a_run = int'(run0); a_cnt = int'(cnt0); end
          1:       begin a_hit = int'(hit1); a_run = int'(run1); a_cnt = int'(cnt1); end
          default: begin a_hit = int'(hit2); a_run = int'(run2); a_cnt = int'(cnt2); end
        endcase
        chk($sformatf("model_hit[u%0d]", k), a_hit, exp_hit);
        chk($sformatf("model_run_len[u%0d]", k), a_run, m_run[k]);
        chk($sformatf("model_hit_count[u%0d]", k), a_cnt, m_cnt[k]);
      end
    end
  end

  // One beat on u0: literal hit checked mid-cycle, literal run_len after the edge (-1 skips).
  task automatic step(input logic v, input logic [3:0] d, input int exp_hit, input int exp_run);
    in_valid = v;
    in_data  = d;
    @(negedge clk);
    if (exp_hit >= 0) chk("hit", int'(hit0), exp_hit);
    @(posedge clk);
    #1;
    if (exp_run >= 0) chk("run_len", int'(run0), exp_run);
  endtask

  task automatic do_clr();
    clr      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; mode = 1'b0; in_valid = 1'b1; in_data = 4'hD;
    pattern = 4'hD; mask = 4'hF;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_hit_mealy", int'(hit0), 0);
    chk("reset_run_len", int'(run0), 0);
    chk("reset_hit_count", int'(cnt0), 0);
    in_valid = 1'b0;
    reset    = 1'b0;
    check_en = 1'b1;

    // Mealy D,D,D,3,D
    step(1, 4'hD, 0, 1); step(1, 4'hD, 1, 2); step(1, 4'hD, 1, 2);
    step(1, 4'h3, 0, 0); step(1, 4'hD, 0, 1);
    chk("mealy_hit_count", int'(cnt0), 2);
    do_clr();
    chk("clr_hit_count", int'(cnt0), 0);

    // Moore, same stream
    mode = 1'b1;
    step(1, 4'hD, 0, 1); step(1, 4'hD, 0, 2); step(1, 4'hD, 1, 2);
    step(1, 4'h3, 1, 0); step(1, 4'hD, 0, 1);
    chk("moore_hit_count", int'(cnt0), 2);
    step(0, 4'h0, 0, 1);
    do_clr();

    // Gap tolerance in Mealy, then switch to Moore mid-run
    mode = 1'b0;
    step(1, 4'hD, 0, 1); step(0, 4'h0, 0, 1); step(0, 4'h0, 0, 1); step(0, 4'h0, 0, 1);
    step(1, 4'hD, 1, 2); step(0, 4'h0, 0, 2);
    mode = 1'b1;
    step(0, 4'h0, 1, 2); step(0, 4'h0, 1, 2); step(1, 4'hD, 1, 2);
    step(1, 4'h3, 1, 0); step(0, 4'h0, 0, 0);
    chk("gap_hit_count", int'(cnt0), 2);
    do_clr();

    // Masked compare
    mode = 1'b0; mask = 4'hC; pattern = 4'hC;
    step(1, 4'hC, 0, 1); step(1, 4'hF, 1, 2); step(1, 4'hD, 1, 2);
    chk("mask_hit_count", int'(cnt0), 2);
    mask = 4'h0;
    step(1, 4'h5, 1, 2); step(1, 4'hA, 1, 2);
    do_clr();

    // clr on the completing beat discards the run
    mask = 4'hF; pattern = 4'hD;
    step(1, 4'hD, 0, 1);
    clr = 1'b1; in_valid = 1'b1; in_data = 4'hD;
    @(negedge clk);
    chk("clr_beat_hit", int'(hit0), 0);
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_run_len", int'(run0), 0);
    chk("clr_count", int'(cnt0), 0);
    step(1, 4'hD, 0, 1); step(1, 4'hD, 1, 2);
    do_clr();

    // Saturation on the 2-bit counter: five hit events
    for (int i = 0; i < 6; i++) step(1, 4'hD, (i == 0) ? 0 : 1, -1);
    chk("sat_hit_count_w2", int'(cnt1), 3);
    chk("sat_hit_count_w16", int'(cnt0), 5);

    // Reset mid-run in Moore drops the level
    mode = 1'b1;
    reset = 1'b1; in_valid = 1'b1; in_data = 4'hD;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("reset_midrun_run_len", int'(run0), 0);
    step(0, 4'h0, 0, 0);

    // MATCH_COUNT = 1: every matching word hits immediately
    mode = 1'b0;
    in_valid = 1'b1; in_data = 4'hD;
    @(negedge clk);
    chk("mc1_hit", int'(hit2), 1);
    @(posedge clk); #1;
    chk("mc1_run_len", int'(run2), 1);
    in_data = 4'h3;
    @(negedge clk);
    chk("mc1_nomatch_hit", int'(hit2), 0);
    @(posedge clk); #1;
    chk("mc1_nomatch_run_len", int'(run2), 0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_match_detector.md
Name: seq_match_detector

Overview:
- Parametrised Mealy/Moore detector for runs of consecutive matching input words.
- Flags when MATCH_COUNT consecutive valid WIDTH-bit words equal a runtime-programmable pattern under a runtime mask. Matching is overlapping.
- Sits on a valid-qualified input stream as a pattern/run monitor. Also keeps a saturating hit counter for status readout.

Parameters:
- WIDTH, 4, input word width in bits (>=1).
- MATCH_COUNT, 2, consecutive matching valid words needed for a hit (>=1).
- CNT_W, 16, hit counter width.
- RUN_W, $clog2(MATCH_COUNT+1), run counter width (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- clr  input  1  synchronous clear of run state and hit_count; no effect on config inputs.
- mode  input  1  0 = Mealy output, 1 = Moore output.
- in_valid  input  1  in_data qualifies this cycle.
- in_data  input  WIDTH  stream word.
- pattern  input  WIDTH  match pattern, sampled combinationally each beat.
- mask  input  WIDTH  1 = bit compared, 0 = don't care.
- hit  output  1  detection output; meaning depends on mode.
- run_len  output  RUN_W  current consecutive-match count, saturating at MATCH_COUNT.
- hit_count  output  CNT_W  number of hit events, saturating at all-ones.

Behaviour:
- Clock clk; reset is synchronous, active-high, and has priority over clr and all stream activity.
- Reset or clr:
  - state <= IDLE, run_len <= 0, hit_count <= 0.
  - hit is 0 in the cycle after. In Mealy mode, hit is combinationally forced to 0 while reset or clr is high.
- match = ((in_data ^ pattern) & mask) == 0. With mask == 0, every valid word matches.
- Accepted beat: in_valid == 1. Non-valid cycles hold all state, run_len and hit_count. A gap does not break a run.
- States:
  - IDLE: run_len == 0.
  - COUNTING: 0 < run_len < MATCH_COUNT.
  - MATCHED: run_len == MATCH_COUNT.
- Transitions on an accepted beat:
  - Non-match: go to IDLE, run_len <= 0.
  - Match: run_len <= min(run_len+1, MATCH_COUNT). State follows run_len.
  - MATCHED with a match stays in MATCHED (overlapping: every further matching word is a hit).
  - MATCH_COUNT == 1: COUNTING is unreachable; IDLE goes directly to MATCHED.
- Hit event = accepted beat with match and run_len >= MATCH_COUNT-1, i.e. the beat that completes or extends a full run.
- Mealy (mode=0):
  - hit = hit event, combinational, in the same cycle as the completing beat (zero latency).
  - hit is 0 on non-valid cycles.
- Moore (mode=1):
  - hit = (state == MATCHED), registered, one cycle after the completing beat.
  - Stays high through non-valid gaps.
  - Drops the cycle after a non-matching accepted beat.
- hit_count increments by 1 on each hit event in both modes; it saturates and holds at 2^CNT_W-1.
- Changing mode mid-stream changes only hit decoding, never state or counters.
- Changing pattern or mask mid-run takes effect on the next compared beat; run_len is not reset.
- Reset or clr asserted mid-run discards the run. The beat presented in that cycle is ignored, and no hit or count is produced for it.

Decomposition:
- Shared package seq_match_pkg:
  - State enum {IDLE, COUNTING, MATCHED} (2-bit encoding).
  - Localparam MODE_MEALY = 1'b0.
  - Localparam MODE_MOORE = 1'b1.
- One sub-module, sat_counter (parameter W): increment enable, synchronous clear, saturating at all-ones. Used for hit_count.
- run_len/state logic stays in the top module.

Test Plan:
- Mealy, WIDTH=4, MATCH_COUNT=2, pattern=4'b1101, mask=4'hF. Valid stream D,D,D,3,D:
  - hit=0,1,1,0,0 in the same cycles.
  - run_len=1,2,2,0,1.
  - hit_count ends at 2.
- Moore, same stream:
  - hit=0,0,1,1,0 (one-cycle delayed level).
  - hit_count ends at 2.
- Gap tolerance. Stream D, then in_valid=0 for 3 cycles, then D:
  - Mealy: hit=1 only on the second D.
  - Moore: hit stays 1 after it until the next non-match.
- Mask: mask=4'b1100, pattern=4'b1100, stream C,F,D:
  - All match; hits on F and D.
  - hit_count=2.
- Reset/clr. Assert clr on the cycle the second D arrives:
  - No hit.
  - run_len=0 and hit_count=0 the next cycle.
  - A subsequent D,D gives a hit on the second D.
- Saturation and edge parameters:
  - CNT_W=2: 5 hit events -> hit_count holds at 3.
  - MATCH_COUNT=1: every matching valid word gives Mealy hit=1, run_len=1.
